ins_sched: RTL

Instruction fetch and dispatch controller for the execution engine. Walks the instruction RAM from a host-given start address and reads each 512-bit instruction. Decodes opcode field ins[7:0] and hands the instruction to exactly one execution unit (Conv, Add or Remap) through a start/done handshake. Units run strictly one at a time. Runs until an End opcode or an illegal opcode, then reports status and performance counters to the host control registers.

---
 rtl/ins_sched_if.sv | 44 ++++
 rtl/ins_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ins_sched_if.sv
// Bundles the host control, instruction-RAM and execution-unit signals of ins_sched.
// The master modport is the scheduler; the slave modport is everything around it.
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 512
`endif

interface ins_sched_if #(
    parameter int INS_WIDTH = `INS_RAM_DATA_WIDTH,
    parameter int INS_DEPTH = 1024
);
    localparam int AW = $clog2(INS_DEPTH);

    logic                 start;
    logic [AW-1:0]        start_addr;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        err_pc;
    logic [AW-1:0]        pc;
    logic                 ins_ram_en;
    logic [AW-1:0]        ins_ram_addr;
    logic [INS_WIDTH-1:0] ins_ram_dout;
    logic [INS_WIDTH-1:0] ins;
    logic                 conv_start;
    logic                 add_start;
    logic                 remap_start;
    logic                 conv_done;
    logic                 add_done;
    logic                 remap_done;
    logic [31:0]          n_exec;
    logic [31:0]          n_cycles;

    modport master (
        input  start, start_addr, ins_ram_dout, conv_done, add_done, remap_done,
        output busy, done, err, err_pc, pc, ins_ram_en, ins_ram_addr, ins,
               conv_start, add_start, remap_start, n_exec, n_cycles
    );

    modport slave (
        output start, start_addr, ins_ram_dout, conv_done, add_done, remap_done,
        input  busy, done, err, err_pc, pc, ins_ram_en, ins_ram_addr, ins,
               conv_start, add_start, remap_start, n_exec, n_cycles
    );
endinterface

// File: rtl/ins_sched.sv
// Instruction fetch/dispatch controller: walks instruction RAM from a host start address,
// hands each instruction to one execution unit at a time, and stops on End or an illegal opcode.
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 512
`endif

module ins_sched #(
    parameter int INS_WIDTH = `INS_RAM_DATA_WIDTH,
    parameter int INS_DEPTH = 1024
) (
    input logic         clk,
    input logic         rst,
    ins_sched_if.master bus
);
    localparam int AW = $clog2(INS_DEPTH);

    localparam logic [7:0]    OP_END   = 8'h00;
    localparam logic [7:0]    OP_CONV  = 8'h01;
    localparam logic [7:0]    OP_ADD   = 8'h02;
    localparam logic [7:0]    OP_REMAP = 8'h03;
    localparam logic [AW-1:0] PC_LAST  = AW'(INS_DEPTH - 1);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        EXEC,
        FIN
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_pc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [AW-1:0]        r_errPc;
    logic                 r_ramEn;
    logic [INS_WIDTH-1:0] r_ins;
    logic                 r_convStart;
    logic                 r_addStart;
    logic                 r_remapStart;
    logic [31:0]          r_nExec;
    logic [31:0]          r_nCycles;

    logic [7:0]           w_op;
    logic                 w_unitDone;
    logic                 w_dispatching;
    logic [AW-1:0]        w_pcNext;

    assign w_op          = r_ins[7:0];
    assign w_dispatching = r_convStart | r_addStart | r_remapStart;
    assign w_pcNext      = (r_pc == PC_LAST) ? '0 : r_pc + PC_ONE;

    // Only the unit selected by the held opcode may end the EXEC wait.
    always_comb begin
        w_unitDone = 1'b0;
        case (w_op)
            OP_CONV:  w_unitDone = bus.conv_done;
            OP_ADD:   w_unitDone = bus.add_done;
            OP_REMAP: w_unitDone = bus.remap_done;
            default:  w_unitDone = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_errPc      <= '0;
            r_ramEn      <= 1'b0;
            r_ins        <= '0;
            r_convStart  <= 1'b0;
            r_addStart   <= 1'b0;
            r_remapStart <= 1'b0;
            r_nExec      <= '0;
            r_nCycles    <= '0;
        end else begin
            r_done       <= 1'b0;
            r_ramEn      <= 1'b0;
            r_convStart  <= 1'b0;
            r_addStart   <= 1'b0;
            r_remapStart <= 1'b0;
            if (r_state != IDLE && r_nCycles != '1) begin
                r_nCycles <= r_nCycles + 32'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_pc      <= bus.start_addr;
                        r_err     <= 1'b0;
                        r_errPc   <= '0;
                        r_nExec   <= '0;
                        r_nCycles <= '0;
                        r_busy    <= 1'b1;
                        r_ramEn   <= 1'b1;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_ins   <= bus.ins_ram_dout;
                    r_state <= DECODE;
                end
                DECODE: begin
                    case (w_op)
                        OP_END: begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                        OP_CONV: begin
                            r_convStart <= 1'b1;
                            r_nExec     <= r_nExec + 32'd1;
                            r_state     <= EXEC;
                        end
                        OP_ADD: begin
                            r_addStart <= 1'b1;
                            r_nExec    <= r_nExec + 32'd1;
                            r_state    <= EXEC;
                        end
                        OP_REMAP: begin
                            r_remapStart <= 1'b1;
                            r_nExec      <= r_nExec + 32'd1;
                            r_state      <= EXEC;
                        end
                        default: begin
                            r_err   <= 1'b1;
                            r_errPc <= r_pc;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    endcase
                end
                // A done arriving while our own start pulse is still high belongs to nobody we launched.
                EXEC: begin
                    if (w_unitDone && !w_dispatching) begin
                        r_pc    <= w_pcNext;
                        r_ramEn <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.err_pc       = r_errPc;
    assign bus.pc           = r_pc;
    assign bus.ins_ram_en   = r_ramEn;
    assign bus.ins_ram_addr = r_pc;
    assign bus.ins          = r_ins;
    assign bus.conv_start   = r_convStart;
    assign bus.add_start    = r_addStart;
    assign bus.remap_start  = r_remapStart;
    assign bus.n_exec       = r_nExec;
    assign bus.n_cycles     = r_nCycles;
endmodule
